fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side consumer for the dual-clock FIFO, living entirely in the FIFO read (slow) clock domain. It drains `WIDTH`-bit entries through the FIFO's `rd`/`empty`/`dout` port and packs `RATIO` consecutive entries into one wide word. It presents each word on a valid/ready stream to the next stage. A flush request emits a partially filled word with its byte count.

## Interface
- `WIDTH`, 8: FIFO entry width in bits; must match the FIFO `WIDTH`.
- `RATIO`, 4: entries per output word; legal range 2..16.
- `CNT_W`, `$clog2(RATIO)+1`: width of `dcount`.

- `clock` in 1: read-domain clock, the same net as the FIFO `rclock`.
- `reset` in 1: synchronous, active-high reset.
- `empty` in 1: FIFO empty flag.
- `rd` out 1: FIFO read request.
- `din` in WIDTH: FIFO `dout`.
- `flush` in 1: one-cycle request to emit the partial word.
- `dout` out WIDTH*RATIO: packed word.
- `dcount` out CNT_W: number of valid entries in `dout`, from 1 to RATIO.
- `valid` out 1: `dout` and `dcount` are valid.
- `ready` in 1: downstream accepts the word.

## Operation
- **FIFO contract.**
  - A read is accepted at an edge where `rd=1` and `empty=0`.
  - The entry appears on `din` during the following cycle and is captured at the next edge.
  - `rd=1` while `empty=1` is harmless, but the block must never count it as a read.
- **State.**
  - `pend` (1 bit): an accepted read whose data arrives next cycle.
  - `cnt` (0..RATIO): entries held in the assembly register.
  - Output register: `dout`, `dcount`, `valid`.
  - `flush_pend` (1 bit).
- **Packing order.**
  - The first entry read goes to `dout[WIDTH-1:0]`.
  - Entry k goes to bits `[(k+1)*WIDTH-1 : k*WIDTH]`.
  - Unfilled lanes of a partial word are 0.
- **Transfer to output.** A word moves into the output register at an edge when the output slot is free (`valid=0`, or `valid=1` and `ready=1`) and either:
  - the assembly holds RATIO entries, or
  - the captured entry completes the word. It is merged directly, so there is no extra cycle.
- **Stall.** If the slot is not free, the completed word stays in assembly with `cnt=RATIO` until the slot frees.
- **`rd` generation.** Combinational from registered state and `empty`. `rd=1` iff all of these hold:
  - `reset=0` and `empty=0`;
  - `flush_pend=0`;
  - `cnt + pend - (RATIO if a transfer happens at this edge) < RATIO`.
- **Flush.**
  - `flush` sets `flush_pend`, and `rd` is suppressed from the next cycle.
  - Once `pend=0`:
    - if `cnt>0` and the slot is free, the partial word transfers with `dcount=cnt`, then `cnt` and `flush_pend` clear;
    - if `cnt=0`, `flush_pend` clears with no output.
  - A flush arriving while a full word is completing changes nothing for that word.
  - A flush while `flush_pend=1` is ignored.
- **Handshake.**
  - `valid` holds until `ready`. `dout`/`dcount` are stable while `valid=1` and `ready=0`.
  - Words are never dropped, duplicated or reordered.

## Timing
- **Reset.**
  - At a reset edge: `valid=0`, `dout=0`, `dcount=0`, `cnt=0`, `pend=0`, `flush_pend=0`.
  - `rd=0` while `reset=1`.
  - Reset mid-word discards the partial word and any in-flight read. The FIFO is reset by the same system reset.
- **Latency.**
  - First accepted read at edge E0, with `empty=0` and `ready=1` throughout.
  - Word captured, and `valid=1`, after edge E(RATIO).
- **Throughput.** With `empty=0` and `ready=1`, `rd` stays high continuously and one word is produced per RATIO cycles.
- **Backpressure.**
  - With `ready=0` and the output full, the assembly fills to RATIO, then `rd` drops.
  - `rd` reasserts in the same cycle that `ready=1` frees the slot.
- **Empty gaps.** `empty` gaps only stretch assembly; `cnt` persists across gaps indefinitely.
- **Simultaneous events.** When `ready` consumes and a new word transfers at the same edge, `valid` stays high with the new word.

## Test plan
- **Basic packing.** Reset, write 0x11,0x22,0x33,0x44 into the FIFO, `ready=1` → one word `dout=0x44332211`, `dcount=4`, `valid` for exactly 1 cycle.
- **Streaming.** 32 sequential bytes 0x00..0x1F, `ready=1` → 8 words, 0x03020100 … 0x1F1E1D1C, in order. With the FIFO pre-filled, `rd` has no bubbles.
- **Backpressure.** Write 12 bytes with `ready=0` → first word held stable, assembly holds 4, `rd` low, 4 bytes remain in the FIFO. Then `ready=1` → 3 words, in order, no loss.
- **Flush, partial word.** Write 0xA1,0xB2, wait for `empty`, pulse `flush` → `dout=0x0000B2A1`, `dcount=2`, and no further `rd` until the flush completes. Flush with `cnt=0` → no output.
- **Reset mid-word.** Write 0x01,0x02,0x03, assert `reset` with FIFO and packer together, then write 0x05..0x08 → single word `0x08070605`, `dcount=4`.
- **Random mix.** 100 random bursts of writes (fast clock) and random `ready`/`flush` → a scoreboard matches every byte and `dcount` sum exactly. `rd` is never accepted while `empty=1`.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer for the dual-clock FIFO, read clock domain only.
// Drains WIDTH-bit entries via rd/empty/din and packs RATIO of them into one word
// presented on a valid/ready stream. A flush emits a partial word with its count.
//
// Stream handshake: a word is transferred downstream at a rising clock edge where
// valid=1 and ready=1. Once valid rises, dout/dcount hold steady and valid stays
// high until that edge. ready may toggle freely and has no effect while valid=0.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = $clog2(RATIO) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   empty,
  output logic                   rd,
  input  logic [WIDTH-1:0]       din,
  input  logic                   flush,
  output logic [WIDTH*RATIO-1:0] dout,
  output logic [CNT_W-1:0]       dcount,
  output logic                   valid,
  input  logic                   ready
);

  localparam int OW = WIDTH * RATIO;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
  localparam logic [CNT_W:0]   FILL_MAX = (CNT_W + 1)'(RATIO);

  // pend: a read was accepted at the last edge, its entry is on din now
  logic             pend;
  logic             flush_pend;
  logic [CNT_W-1:0] cnt;
  logic [OW-1:0]    asm_q;

  logic [OW-1:0]    asm_merged;
  logic [CNT_W:0]   fill;
  logic             slot_free;
  logic             xfer_full;
  logic             xfer_part;
  logic             xfer;
  logic             flush_done;

  // Assembly contents with the entry on din (if any) dropped into lane cnt
  always_comb begin
    asm_merged = asm_q;
    for (int i = 0; i < RATIO; i++) begin
      if (pend && (cnt == CNT_W'(i))) begin
        asm_merged[i*WIDTH +: WIDTH] = din;
      end
    end
  end

  // Transfer decisions for this edge and the FIFO read request
  always_comb begin
    slot_free  = !valid || ready;
    fill       = {1'b0, cnt} + {{CNT_W{1'b0}}, pend};
    // A full word moves out either from a completed assembly or directly as the
    // captured entry completes it; the invariant cnt+pend <= RATIO means a
    // completed assembly never has a read in flight.
    xfer_full  = slot_free && ((cnt == CNT_FULL) || (pend && (cnt == CNT_LAST)));
    // Partial words leave only once the last in-flight read has landed
    xfer_part  = slot_free && flush_pend && !pend &&
                 (cnt != '0) && (cnt != CNT_FULL);
    xfer       = xfer_full || xfer_part;
    flush_done = flush_pend && !pend && ((cnt == '0) || xfer_part);
    // After this edge the assembly holds fill entries, minus RATIO if a full
    // word leaves; read only if there is room for one more.
    rd         = !reset && !empty && !flush_pend &&
                 (xfer_full || (fill < FILL_MAX));
  end

  // Read tracking, word assembly, output register and flush bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      pend       <= 1'b0;
      flush_pend <= 1'b0;
      cnt        <= '0;
      asm_q      <= '0;
      dout       <= '0;
      dcount     <= '0;
      valid      <= 1'b0;
    end else begin
      pend <= rd;

      if (xfer) begin
        dout   <= asm_merged;
        dcount <= xfer_full ? CNT_FULL : cnt;
        valid  <= 1'b1;
        asm_q  <= '0;
        cnt    <= '0;
      end else begin
        if (ready) begin
          valid <= 1'b0;
        end
        if (pend) begin
          asm_q <= asm_merged;
          cnt   <= cnt + 1'b1;
        end
      end

      // A second flush while one is outstanding is absorbed
      if (flush_done) begin
        flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural read-domain FIFO, directed packing,
// streaming, backpressure, flush and reset cases, then a random byte-level mix.
module tb_fifo_rd_packer;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;
  localparam int CNT_W = $clog2(RATIO) + 1;
  localparam int DW    = WIDTH * RATIO;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset;
  logic             empty;
  logic             rd;
  logic [WIDTH-1:0] din;
  logic             flush;
  logic [DW-1:0]    dout;
  logic [CNT_W-1:0] dcount;
  logic             valid;
  logic             ready;

  always #5 clock = ~clock;

  fifo_rd_packer #(
    .WIDTH(WIDTH),
    .RATIO(RATIO),
    .CNT_W(CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .empty (empty),
    .rd    (rd),
    .din   (din),
    .flush (flush),
    .dout  (dout),
    .dcount(dcount),
    .valid (valid),
    .ready (ready)
  );

  // ---------------- scoreboard state ----------------
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] byte_q[$];
  logic [DW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_c_q[$];
  int n_cmp      = 0;
  int n_err      = 0;
  int n_extra    = 0;
  int n_rd_empty = 0;
  int dsum       = 0;
  int n_written  = 0;
  bit rand_mode  = 1'b0;
  bit last_acc   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a handshake: compare the word leaving the block
  task automatic consume();
    logic [DW-1:0] e;
    if (!rand_mode) begin
      if (exp_q.size() == 0) begin
        n_extra++;
      end else begin
        e = exp_q.pop_front();
        check("word_data", 64'(dout), 64'(e));
        check("word_dcount", 64'(dcount), 64'(exp_c_q.pop_front()));
      end
    end else begin
      dsum += int'(dcount);
      for (int i = 0; i < RATIO; i++) begin
        if (i < int'(dcount)) begin
          if (byte_q.size() == 0) n_extra++;
          else check("rand_byte", 64'(dout[i*WIDTH +: WIDTH]), 64'(byte_q.pop_front()));
        end else begin
          check("rand_pad", 64'(dout[i*WIDTH +: WIDTH]), 64'd0);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle, entered and left just after a falling edge.
  task automatic step();
    logic acc, take, hold;
    logic [DW-1:0]    held_d;
    logic [CNT_W-1:0] held_c;
    #1;
    acc    = rd && !empty;
    take   = valid && ready;
    hold   = valid && !ready;
    held_d = dout;
    held_c = dcount;
    if (rd && empty) n_rd_empty++;
    last_acc = acc;
    if (take) consume();
    @(posedge clock);
    @(negedge clock);
    if (hold && !reset) begin
      check("hold_valid", 64'(valid), 64'd1);
      check("hold_dout", 64'(dout), 64'(held_d));
      check("hold_dcount", 64'(dcount), 64'(held_c));
    end
    if (acc && fifo_q.size() != 0) din = fifo_q.pop_front();
    empty = (fifo_q.size() == 0);
    flush = 1'b0;
  endtask

  task automatic wr_byte(input logic [WIDTH-1:0] b);
    fifo_q.push_back(b);
    empty = 1'b0;
    if (rand_mode) begin
      byte_q.push_back(b);
      n_written++;
    end
  endtask

  task automatic expect_word(input logic [DW-1:0] w, input logic [CNT_W-1:0] c);
    exp_q.push_back(w);
    exp_c_q.push_back(c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    fifo_q.delete();
    empty = 1'b0;
    #1 check("rd_in_reset", 64'(rd), 64'd0);
    step();
    step();
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_dout", 64'(dout), 64'd0);
    check("reset_dcount", 64'(dcount), 64'd0);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    ready = 1'b1;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || valid) && i < 200) begin
      step();
      i++;
    end
    check({tag, "_missing"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_extra"}, 64'(n_extra), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] vtrace;
    int n_acc;
    int i;
    logic vseen;
    reset = 1'b1;
    empty = 1'b1;
    din   = '0;
    flush = 1'b0;
    ready = 1'b0;

    do_reset();

    // Basic packing and first-word latency
    ready = 1'b1;
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
    expect_word(32'h44332211, 3'd4);
    vtrace = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      vtrace[k] = valid;
    end
    check("basic_valid_trace", 64'(vtrace), 64'h10);
    drain("basic");

    // Streaming 0x00..0x1F from a pre-filled FIFO
    for (int k = 0; k < 32; k++) wr_byte(8'(k));
    for (int w = 0; w < 8; w++)
      expect_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 3'd4);
    n_acc = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (last_acc) n_acc++;
    end
    check("stream_rd_nobubble", 64'(n_acc), 64'd32);
    drain("stream");

    // Backpressure: 12 bytes with ready low
    ready = 1'b0;
    for (int k = 0; k < 12; k++) wr_byte(8'(8'h40 + k));
    expect_word(32'h43424140, 3'd4);
    expect_word(32'h47464544, 3'd4);
    expect_word(32'h4B4A4948, 3'd4);
    for (int k = 0; k < 15; k++) step();
    check("bp_valid", 64'(valid), 64'd1);
    check("bp_dout", 64'(dout), 64'h43424140);
    check("bp_fifo_left", 64'(fifo_q.size()), 64'd4);
    #1 check("bp_rd_low", 64'(rd), 64'd0);
    ready = 1'b1;
    #1 check("bp_rd_reassert", 64'(rd), 64'd1);
    drain("bp");

    // Flush of a partial word, rd blocked while the flush is pending
    wr_byte(8'hA1); wr_byte(8'hB2);
    for (int k = 0; k < 5; k++) step();
    expect_word(32'h0000B2A1, 3'd2);
    flush = 1'b1;
    step();
    wr_byte(8'hC3);
    #1 check("flush_rd_blocked", 64'(rd), 64'd0);
    step();
    check("flush_valid", 64'(valid), 64'd1);
    for (int k = 0; k < 5; k++) step();
    expect_word(32'h000000C3, 3'd1);
    flush = 1'b1;
    step();
    drain("flush1");
    // Flush with nothing assembled produces no word
    flush = 1'b1;
    step();
    vseen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      vseen = vseen | valid;
    end
    check("flush_empty_no_word", 64'(vseen), 64'd0);
    drain("flush0");

    // Reset in the middle of a word
    ready = 1'b1;
    wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
    for (int k = 0; k < 3; k++) step();
    do_reset();
    wr_byte(8'h05); wr_byte(8'h06); wr_byte(8'h07); wr_byte(8'h08);
    expect_word(32'h08070605, 3'd4);
    drain("reset_mid");

    // Random mix at byte granularity
    rand_mode = 1'b1;
    for (int b = 0; b < 100; b++) begin
      int nb, ns;
      nb = $urandom_range(0, 6);
      for (int k = 0; k < nb; k++) wr_byte(8'($urandom_range(0, 255)));
      ns = $urandom_range(1, 6);
      for (int s = 0; s < ns; s++) begin
        ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 7) == 0);
        step();
      end
    end
    ready = 1'b1;
    i = 0;
    while (fifo_q.size() != 0 && i < 2000) begin
      step();
      i++;
    end
    for (int k = 0; k < 4; k++) step();
    flush = 1'b1;
    step();
    i = 0;
    while ((valid || byte_q.size() != 0) && i < 20) begin
      step();
      i++;
    end
    check("rand_bytes_left", 64'(byte_q.size()), 64'd0);
    check("rand_dcount_sum", 64'(dsum), 64'(n_written));
    check("rand_extra", 64'(n_extra), 64'd0);
    check("rd_while_empty", 64'(n_rd_empty), 64'd0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
